// File: rtl/ifq_pkg.sv
// rtl/ifq_pkg.sv - shared fetch-queue types, constants and helpers
package ifq_pkg;

    // Fetch FSM encodings
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] IFQ_RESET_PC = 32'h0000_0000;
    localparam int          IFQ_W_DATA   = 64;

    // Instruction fetches are always word aligned
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// rtl/ifq_fifo.sv - first-word-fall-through queue with flush
module ifq_fifo #(
    parameter int DEPTH  = 16,
    parameter int W_PTR  = 4,
    parameter int W_DATA = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wen,
    input  logic [W_DATA-1:0] wdata,
    input  logic              ren,
    input  logic              flush,
    output logic [W_DATA-1:0] rdata,
    output logic              empty,
    output logic              full,
    output logic [W_PTR:0]    count
);

    localparam logic [W_PTR:0] PTR_ONE = {{W_PTR{1'b0}}, 1'b1};

    logic [W_DATA-1:0] mem [DEPTH];
    logic [W_PTR:0]    wr_ptr;
    logic [W_PTR:0]    rd_ptr;
    logic              do_wr;
    logic              do_rd;

    // Flush dominates: neither a write nor a read takes effect in a flush cycle
    assign do_wr = wen && !full && !flush;
    assign do_rd = ren && !empty && !flush;

    // Extra pointer MSB distinguishes full from empty when low bits match
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[W_PTR] != rd_ptr[W_PTR]) &&
                   (wr_ptr[W_PTR-1:0] == rd_ptr[W_PTR-1:0]);
    assign count = wr_ptr - rd_ptr;

    // Head is presented combinationally; zero when nothing is queued
    assign rdata = empty ? '0 : mem[rd_ptr[W_PTR-1:0]];

    // Pointer update: flush resets both, otherwise advance on accepted write/read
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[W_PTR-1:0]] <= wdata;
    end

endmodule

// File: rtl/ifq.sv
// rtl/ifq.sv - instruction fetch queue with branch flush and redirect
module ifq
    import ifq_pkg::*;
#(
    parameter int          DEPTH    = 16,
    parameter int          W_PTR    = 4,
    parameter logic [31:0] RESET_PC = IFQ_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    output logic        imem_ren,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        imem_rvalid,
    input  logic        dispatch_ren,
    input  logic        dispatch_branch_valid,
    input  logic [31:0] dispatch_branch_addr,
    output logic [31:0] dispatch_inst,
    output logic [31:0] dispatch_pcout_plus4,
    output logic        dispatch_empty
);

    localparam logic [W_PTR:0] DEPTH_CNT = (W_PTR+1)'(DEPTH);
    localparam logic [W_PTR:0] CNT_ONE   = {{W_PTR{1'b0}}, 1'b1};

    fetch_state_t          state;
    fetch_state_t          state_next;
    logic [31:0]           pc_r;
    logic [31:0]           pc_next;
    logic [31:0]           req_addr_r;
    logic                  drop_r;
    logic                  drop_next;
    logic                  push;
    logic                  pop;
    logic                  fifo_full;
    logic [W_PTR:0]        count;
    logic [W_PTR:0]        cnt_after;
    logic [31:0]           target;
    logic [IFQ_W_DATA-1:0] fifo_rdata;

    assign target   = word_align(dispatch_branch_addr);
    assign imem_ren = (state == S_REQ);
    // req_addr_r holds the in-flight request PC through S_REQ and S_WAIT
    assign imem_addr = req_addr_r;

    assign push = (state == S_WAIT) && imem_rvalid && !drop_r &&
                  !dispatch_branch_valid && !fifo_full;
    assign pop  = dispatch_ren && !dispatch_empty && !dispatch_branch_valid;

    // Occupancy after this cycle's push/pop; a flush empties the queue
    assign cnt_after = dispatch_branch_valid ? '0 :
                       count + (push ? CNT_ONE : '0) - (pop ? CNT_ONE : '0);

    // Next-state, next-PC and drop tracking
    always_comb begin
        state_next = state;
        pc_next    = pc_r;
        drop_next  = drop_r;
        case (state)
            S_IDLE: begin
                if (dispatch_branch_valid || (count < DEPTH_CNT)) state_next = S_REQ;
            end
            S_REQ: begin
                if (imem_ready) begin
                    state_next = S_WAIT;
                    // A redirect seen while pending already holds the new PC
                    if (!drop_r) pc_next = pc_r + 32'd4;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    drop_next  = 1'b0;
                    state_next = (cnt_after < DEPTH_CNT) ? S_REQ : S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (dispatch_branch_valid) begin
            pc_next = target;
            // Mark the outstanding request stale unless its response is arriving now
            if ((state == S_REQ) || ((state == S_WAIT) && !imem_rvalid)) drop_next = 1'b1;
        end
    end

    // FSM, PC, request address and drop flag registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            pc_r       <= RESET_PC;
            req_addr_r <= RESET_PC;
            drop_r     <= 1'b0;
        end else begin
            state  <= state_next;
            pc_r   <= pc_next;
            drop_r <= drop_next;
            if ((state == S_IDLE) || ((state_next == S_REQ) && (state != S_REQ)))
                req_addr_r <= pc_next;
        end
    end

    ifq_fifo #(
        .DEPTH  (DEPTH),
        .W_PTR  (W_PTR),
        .W_DATA (IFQ_W_DATA)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .wen   (push),
        .wdata ({req_addr_r + 32'd4, imem_rdata}),
        .ren   (dispatch_ren),
        .flush (dispatch_branch_valid),
        .rdata (fifo_rdata),
        .empty (dispatch_empty),
        .full  (fifo_full),
        .count (count)
    );

    assign dispatch_inst        = fifo_rdata[31:0];
    assign dispatch_pcout_plus4 = fifo_rdata[63:32];

endmodule

// File: doc/ifq.md
Name: ifq

Overview:
Instruction fetch queue. Generates sequential PCs, fetches 32-bit instructions from instruction memory over a valid/ready request and a response-valid handshake, and buffers them with their PC+4. Presents the head entry first-word-fall-through to dispatch. Flushes and redirects on the branch/jump indication from dispatch.

Parameters:
DEPTH, 16, queue entries; power of 2, minimum 2.
W_PTR, 4, log2(DEPTH).
RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
clk  in  1  clock, all state on posedge.
reset  in  1  asynchronous, active-low reset.
imem_addr  out  32  fetch address, word aligned.
imem_ren  out  1  fetch request valid.
imem_ready  in  1  memory accepts the request this cycle.
imem_rdata  in  32  returned instruction.
imem_rvalid  in  1  imem_rdata valid; exactly one response per accepted request, in order.
dispatch_ren  in  1  pop the head entry.
dispatch_branch_valid  in  1  flush and redirect.
dispatch_branch_addr  in  32  redirect target.
dispatch_inst  out  32  head instruction; 0 when empty.
dispatch_pcout_plus4  out  32  head PC+4; 0 when empty.
dispatch_empty  out  1  queue empty.

Behaviour:
- Reset (reset low, async): queue empty; dispatch_empty=1; dispatch_inst=0; dispatch_pcout_plus4=0; imem_ren=0; imem_addr=RESET_PC; pc_r=RESET_PC; fetch FSM=S_IDLE; drop_r=0.
- Fetch FSM states:
  - S_IDLE: go to S_REQ when credit is available, i.e. count < DEPTH.
  - S_REQ: imem_ren=1, imem_addr=pc_r. Addr is held stable until imem_ready. On accept: pc_r<=pc_r+4, the request PC is latched, go to S_WAIT.
  - S_WAIT: on imem_rvalid, push {latched PC+4, imem_rdata} unless drop_r. Then go to S_REQ if credit remains after this cycle's push/pop, else S_IDLE.
- One outstanding request maximum. Credit counts the in-flight slot, so a push never finds the queue full.
- Best-case throughput: one instruction per 2 cycles with single-cycle memory.
- Pop: dispatch_ren && !dispatch_empty advances the head pointer. dispatch_ren while empty is ignored.
- Output timing: the outputs are combinational from the head entry (FWFT). A pushed entry is visible the cycle after imem_rvalid.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Pointers: W_PTR+1 bits. Wrap is natural modulo DEPTH. full = MSBs differ and the low bits are equal.
- Flush (dispatch_branch_valid=1):
  - Next cycle: queue empty and pc_r=dispatch_branch_addr.
  - A same-cycle dispatch_ren is ignored.
  - A same-cycle imem_rvalid is not pushed.
  - In S_REQ: the pending request stays asserted with its old address until accepted, and drop_r is set. After it is accepted, pc_r must not be incremented, so the redirect target is preserved.
  - In S_WAIT: drop_r is set and the response is discarded on arrival.
  - drop_r clears when the dropped response arrives. Fetch then resumes from the redirect PC.
  - If the flush occurs in S_IDLE, the next request uses the target address.
- Back-to-back flushes: the last target wins. drop_r covers at most the one outstanding request.
- A redirect target that is not word aligned has bits [1:0] forced to 0.
- Reset mid-operation (S_WAIT): all state cleared. A response arriving after reset release while in S_IDLE/S_REQ is ignored (no push).

Decomposition:
- globals.vh: IFQ FSM state encodings (S_IDLE, S_REQ, S_WAIT) and the default RESET_PC.
- Sub-module ifq_fifo: synchronous FWFT FIFO.
  - Parameters: DEPTH, W_DATA=64.
  - Ports: wen, wdata, ren, flush, rdata, empty, full, count.
  - Same clk and async active-low reset.
- ifq top: fetch FSM, pc_r, drop_r and the credit logic.

Test Plan:
- Reset release with 1-cycle imem (ready=1, rvalid the next cycle):
  - first request at 0x0;
  - imem_addr sequence 0x0, 0x4, 0x8;
  - head shows inst0 and pcout_plus4=0x4;
  - dispatch_empty deasserts 3 cycles after reset release.
- Fill with dispatch_ren=0:
  - exactly 16 entries accepted;
  - imem_ren stays 0 after the 16th request until a pop.
  - One pop then allows exactly one new request.
- Full queue with dispatch_ren=1 continuously:
  - entries are popped in order with correct pcout_plus4 across the pointer wrap (entries 15, 16, 17);
  - no loss or duplication.
- Branch in S_WAIT (target 0x100), memory delays rvalid 3 cycles:
  - queue empty next cycle;
  - the late response is discarded;
  - the next imem_addr is 0x100;
  - the first valid head has pcout_plus4=0x104.
- Branch in S_REQ with imem_ready held low 2 cycles (target 0x200):
  - old address held until accepted, then its response is dropped;
  - next request is 0x200.
- Simultaneous cases, each in turn:
  - branch with dispatch_ren: no pop effect, queue empty;
  - branch with imem_rvalid: no push, queue empty;
  - async reset asserted in S_WAIT: outputs return to reset values immediately; a stray rvalid after release causes no push.
